// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (8 data bits, optional parity, 1 stop)
// with majority-voted bits, a single-entry valid/ready holding register and error pulses.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0
) (
  input  logic       clk_100mhz,
  input  logic       sys_rst_i,
  input  logic       terminal_rx,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int T_W     = $clog2(OVERSAMPLE);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(OVERSAMPLE - 1);
  localparam logic [T_W-1:0]   T_S0     = T_W'(M - 1);
  localparam logic [T_W-1:0]   T_S1     = T_W'(M);
  localparam logic [T_W-1:0]   T_DEC    = T_W'(M + 1);
  localparam bit               PAR_EN   = (PARITY != 0);
  localparam bit               PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, rxs_q;
  logic [1:0]       fill_q, fill_d;
  logic             rxs_hi_q, rxs_hi_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       samp_q, samp_d;
  logic             par_err_q, par_err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;

  logic counting, phase_start, div_wrap, bit_end, at_decide, vote, start_edge;
  logic latch_bit, check_par, byte_ok, par_fail, frame_fail, exp_par, load;

  // Shared timing terms: each phase t has exactly one cycle with div_cnt_q == 0,
  // which is where the three vote samples and the bit decision are taken.
  assign counting    = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
  assign phase_start = (div_cnt_q == '0);
  assign div_wrap    = (div_cnt_q == DIV_LAST);
  assign bit_end     = div_wrap && (t_q == T_LAST);
  assign at_decide   = counting && phase_start && (t_q == T_DEC);
  assign vote        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign start_edge  = rxs_hi_q && !rxs_q;
  assign exp_par     = PAR_ODD ? ~(^shift_q) : (^shift_q);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_100mhz or posedge sys_rst_i) begin
    if (sys_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  // NOTE: every always_comb assigns its outputs a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START: begin
        if (at_decide && vote) state_d = S_IDLE;
        else if (bit_end)      state_d = S_DATA;
      end
      S_DATA:   if (bit_end && (bit_idx_q == 3'd7)) state_d = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (at_decide) state_d = vote ? S_IDLE : S_BREAK;
      S_BREAK:  if (rxs_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    latch_bit  = 1'b0;
    check_par  = 1'b0;
    byte_ok    = 1'b0;
    par_fail   = 1'b0;
    frame_fail = 1'b0;
    unique case (state_q)
      S_DATA:   latch_bit = at_decide;
      S_PARITY: check_par = at_decide;
      S_STOP: begin
        byte_ok    = at_decide && vote && !par_err_q;
        par_fail   = at_decide && vote && par_err_q;
        frame_fail = at_decide && !vote;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    // The edge detector only arms once the synchronizer holds real line samples,
    // so a line held low through reset is never mistaken for a start bit.
    fill_d   = {fill_q[0], 1'b1};
    rxs_hi_d = fill_q[1] ? rxs_q : 1'b0;

    div_cnt_d = '0;
    t_d       = '0;
    if (counting) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      t_d       = t_q;
      if (div_wrap) t_d = (t_q == T_LAST) ? '0 : t_q + 1'b1;
    end

    samp_d = samp_q;
    if (counting && phase_start) begin
      if (t_q == T_S0) samp_d[0] = rxs_q;
      if (t_q == T_S1) samp_d[1] = rxs_q;
    end

    bit_idx_d = bit_idx_q;
    if (state_q == S_IDLE)                 bit_idx_d = '0;
    else if ((state_q == S_DATA) && bit_end) bit_idx_d = bit_idx_q + 1'b1;

    shift_d = shift_q;
    if (latch_bit) shift_d[bit_idx_q] = vote;

    par_err_d = par_err_q;
    if (state_q == S_IDLE) par_err_d = 1'b0;
    else if (check_par)    par_err_d = (vote != exp_par);

    // Holding register: a consume in the same cycle frees the slot for the new byte.
    load         = byte_ok && (!valid_q || rx_ready_i);
    data_d       = load ? shift_q : data_q;
    valid_d      = valid_q;
    if (load)                        valid_d = 1'b1;
    else if (valid_q && rx_ready_i)  valid_d = 1'b0;
    overrun_d    = byte_ok && valid_q && !rx_ready_i;
    frame_err_d  = frame_fail;
    parity_err_d = PAR_EN && par_fail;
  end

  // ---------------------------------------------------------------- datapath registers
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100mhz or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      // NOTE: synchronizer flops preset to the idle-high line level, not to zero.
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      fill_q       <= '0;
      rxs_hi_q     <= 1'b0;
      div_cnt_q    <= '0;
      t_q          <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      par_err_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= terminal_rx;
      rxs_q        <= sync1_q;
      fill_q       <= fill_d;
      rxs_hi_q     <= rxs_hi_d;
      div_cnt_q    <= div_cnt_d;
      t_q          <= t_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      par_err_q    <= par_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: one no-parity and one even-parity instance,
// directed scenarios plus randomized frames against a byte-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int OS     = 16;
  localparam int BIT    = 96;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, busy_a, busy_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .PARITY(0)) u_dut_a (
    .clk_100mhz(clk), .sys_rst_i(rst), .terminal_rx(rx_a),
    .rx_data_o(data_a), .rx_valid_o(val_a), .rx_ready_i(rdy_a),
    .busy_o(busy_a), .frame_err_o(fe_a), .parity_err_o(pe_a), .overrun_o(ov_a));

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .PARITY(2)) u_dut_b (
    .clk_100mhz(clk), .sys_rst_i(rst), .terminal_rx(rx_b),
    .rx_data_o(data_b), .rx_valid_o(val_b), .rx_ready_i(rdy_b),
    .busy_o(busy_b), .frame_err_o(fe_b), .parity_err_o(pe_b), .overrun_o(ov_b));

  int n_checks = 0;
  int n_errors = 0;

  // ------------------------------------------------------------ output monitor
  int         fe_cnt[2]   = '{0, 0};
  int         pe_cnt[2]   = '{0, 0};
  int         ov_cnt[2]   = '{0, 0};
  int         unstable[2] = '{0, 0};
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic       pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
  logic [7:0] pd_a = '0, pd_b = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv_a <= 1'b0;
      pv_b <= 1'b0;
    end else begin
      if (fe_a) fe_cnt[0]++;
      if (pe_a) pe_cnt[0]++;
      if (ov_a) ov_cnt[0]++;
      if (fe_b) fe_cnt[1]++;
      if (pe_b) pe_cnt[1]++;
      if (ov_b) ov_cnt[1]++;
      if (val_a && rdy_a) got_a.push_back(data_a);
      if (val_b && rdy_b) got_b.push_back(data_b);
      if (pv_a && !pr_a && val_a && (data_a !== pd_a)) unstable[0]++;
      if (pv_b && !pr_b && val_b && (data_b !== pd_b)) unstable[1]++;
      pv_a <= val_a; pr_a <= rdy_a; pd_a <= data_a;
      pv_b <= val_b; pr_b <= rdy_b; pd_b <= data_b;
    end
  end

  // ------------------------------------------------------------ reference model
  logic       exp_valid[2] = '{1'b0, 1'b0};
  logic [7:0] exp_data[2]  = '{8'h00, 8'h00};
  int         exp_fe[2]    = '{0, 0};
  int         exp_pe[2]    = '{0, 0};
  int         exp_ov[2]    = '{0, 0};
  logic [7:0] exp_got_a[$];
  logic [7:0] exp_got_b[$];

  function automatic logic par_bit(input logic [7:0] b, input int mode);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (mode == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  task automatic push_exp(input int ch, input logic [7:0] b);
    if (ch == 0) exp_got_a.push_back(b);
    else         exp_got_b.push_back(b);
  endtask

  task automatic model_frame(input int ch, input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input logic ready_held);
    if (bad_stop)      exp_fe[ch]++;
    else if (bad_par)  exp_pe[ch]++;
    else if (ready_held) begin
      if (exp_valid[ch]) push_exp(ch, exp_data[ch]);
      exp_valid[ch] = 1'b0;
      push_exp(ch, b);
    end else if (exp_valid[ch]) exp_ov[ch]++;
    else begin
      exp_valid[ch] = 1'b1;
      exp_data[ch]  = b;
    end
  endtask

  // ------------------------------------------------------------ stimulus helpers
  task automatic set_line(input int ch, input logic v);
    if (ch == 0) rx_a = v;
    else         rx_b = v;
  endtask

  task automatic drive_bit(input int ch, input logic v, input int n);
    set_line(ch, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input int ch, input logic [7:0] b, input int par_mode,
                           input logic par_flip, input int n);
    drive_bit(ch, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(ch, b[i], n);
    if (par_mode != 0) drive_bit(ch, par_bit(b, par_mode) ^ par_flip, n);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] b, input logic par_flip,
                            input logic stop_v, input int n);
    send_bits(ch, b, (ch == 1) ? 2 : 0, par_flip, n);
    drive_bit(ch, stop_v, n);
    set_line(ch, 1'b1);
  endtask

  task automatic consume(input int ch);
    @(posedge clk); #1;
    if (ch == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
    @(posedge clk); #1;
    if (ch == 0) rdy_a = 1'b0; else rdy_b = 1'b0;
    if (exp_valid[ch]) begin
      push_exp(ch, exp_data[ch]);
      exp_valid[ch] = 1'b0;
    end
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset;
    int busy_cycles = 0;
    rst = 1'b1; rx_a = 1'b0; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    idle(5);
    n_checks++;
    if ({data_a, val_a, busy_a, fe_a, pe_a, ov_a, data_b, val_b, busy_b, fe_b, pe_b, ov_b} !== '0)
      begin n_errors++; $display("FAIL reset_state: a=%h/%b b=%h/%b expected all zero",
        data_a, {val_a, busy_a, fe_a, pe_a, ov_a}, data_b, {val_b, busy_b, fe_b, pe_b, ov_b}); end
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_a) busy_cycles++;
    end
    #1;
    n_checks++;
    if (busy_cycles !== 0 || val_a !== 1'b0)
      begin n_errors++; $display("FAIL held_low_no_start: busy_cycles=%0d valid=%b expected 0/0",
        busy_cycles, val_a); end
    rx_a = 1'b1;
    idle(20);
  endtask

  task automatic test_single_byte;
    int fe0 = fe_cnt[0], ov0 = ov_cnt[0];
    send_bits(0, 8'h55, 0, 1'b0, BIT);
    drive_bit(0, 1'b1, 70);
    n_checks++;
    if (busy_a !== 1'b0 || val_a !== 1'b1 || data_a !== 8'h55)
      begin n_errors++; $display("FAIL mid_stop_delivery: busy=%b valid=%b data=%h expected 0/1/55",
        busy_a, val_a, data_a); end
    drive_bit(0, 1'b1, BIT - 70);
    model_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    idle(30);
    n_checks++;
    if (val_a !== 1'b1 || data_a !== 8'h55)
      begin n_errors++; $display("FAIL hold_until_ready: valid=%b data=%h expected 1/55", val_a, data_a); end
    consume(0);
    idle(2);
    n_checks++;
    if (val_a !== 1'b0 || fe_cnt[0] != fe0 || ov_cnt[0] != ov0)
      begin n_errors++; $display("FAIL consume_55: valid=%b fe+%0d ov+%0d expected 0/0/0",
        val_a, fe_cnt[0] - fe0, ov_cnt[0] - ov0); end
  endtask

  task automatic test_back_to_back;
    int ov0 = ov_cnt[0], n0 = got_a.size();
    rdy_a = 1'b1;
    send_frame(0, 8'hA3, 1'b0, 1'b1, BIT);
    model_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h0F, 1'b0, 1'b1, BIT);
    model_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
    idle(20);
    rdy_a = 1'b0;
    n_checks++;
    if (got_a.size() != n0 + 2)
      begin n_errors++; $display("FAIL b2b_count: got %0d bytes expected 2", got_a.size() - n0); end
    else begin
      n_checks++;
      if (got_a[n0] !== 8'hA3 || got_a[n0+1] !== 8'h0F)
        begin n_errors++; $display("FAIL b2b_order: got %h %h expected a3 0f", got_a[n0], got_a[n0+1]); end
    end
    n_checks++;
    if (ov_cnt[0] != ov0 || val_a !== 1'b0)
      begin n_errors++; $display("FAIL b2b_no_overrun: ov+%0d valid=%b expected 0/0", ov_cnt[0] - ov0, val_a); end
  endtask

  task automatic test_overrun;
    int ov0 = ov_cnt[0];
    send_frame(0, 8'h11, 1'b0, 1'b1, BIT);
    model_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, BIT);
    model_frame(0, 8'h22, 1'b0, 1'b0, 1'b0);
    idle(20);
    n_checks++;
    if (val_a !== 1'b1 || data_a !== 8'h11 || ov_cnt[0] - ov0 != 1)
      begin n_errors++; $display("FAIL overrun_keep_old: valid=%b data=%h ov+%0d expected 1/11/1",
        val_a, data_a, ov_cnt[0] - ov0); end
    consume(0);
    idle(2);
    n_checks++;
    if (val_a !== 1'b0)
      begin n_errors++; $display("FAIL overrun_consume: valid=%b expected 0", val_a); end
  endtask

  task automatic test_frame_error;
    int fe0 = fe_cnt[0];
    send_bits(0, 8'h3C, 0, 1'b0, BIT);
    drive_bit(0, 1'b0, BIT + 50);
    model_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (busy_a !== 1'b1 || val_a !== 1'b0 || fe_cnt[0] - fe0 != 1)
      begin n_errors++; $display("FAIL frame_err_break: busy=%b valid=%b fe+%0d expected 1/0/1",
        busy_a, val_a, fe_cnt[0] - fe0); end
    drive_bit(0, 1'b1, 20);
    n_checks++;
    if (busy_a !== 1'b0)
      begin n_errors++; $display("FAIL break_exit: busy=%b expected 0", busy_a); end
    send_frame(0, 8'h7E, 1'b0, 1'b1, BIT);
    model_frame(0, 8'h7E, 1'b0, 1'b0, 1'b0);
    idle(10);
    n_checks++;
    if (val_a !== 1'b1 || data_a !== 8'h7E)
      begin n_errors++; $display("FAIL after_break: valid=%b data=%h expected 1/7e", val_a, data_a); end
    consume(0);
  endtask

  task automatic test_false_start;
    int busy_cycles = 0;
    int e0 = fe_cnt[0] + pe_cnt[0] + ov_cnt[0];
    rx_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_a) busy_cycles++;
      if (i == 39) begin #1; rx_a = 1'b1; end
    end
    #1;
    n_checks++;
    if (busy_cycles <= 0 || busy_cycles >= BIT)
      begin n_errors++; $display("FAIL glitch_busy: busy %0d cycles expected 1..95", busy_cycles); end
    n_checks++;
    if (val_a !== 1'b0 || fe_cnt[0] + pe_cnt[0] + ov_cnt[0] != e0)
      begin n_errors++; $display("FAIL glitch_silent: valid=%b new pulses=%0d expected 0/0",
        val_a, fe_cnt[0] + pe_cnt[0] + ov_cnt[0] - e0); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 14; k++) begin
      int         ch   = int'($urandom_range(0, 1));
      logic [7:0] b    = 8'($urandom);
      int         kind = int'($urandom_range(0, 7));
      int         n    = int'($urandom_range(BIT - 2, BIT + 2));
      int         gap  = int'($urandom_range(0, 30));
      logic       bad_stop = (kind == 0);
      logic       bad_par  = (kind == 1) && (ch == 1);
      logic       v;
      logic [7:0] d;
      send_frame(ch, b, bad_par, !bad_stop, n);
      model_frame(ch, b, bad_par, bad_stop, 1'b0);
      v = (ch == 0) ? val_a : val_b;
      d = (ch == 0) ? data_a : data_b;
      n_checks++;
      if (v !== exp_valid[ch] || (exp_valid[ch] && d !== exp_data[ch]))
        begin n_errors++; $display("FAIL random_frame%0d ch%0d: valid=%b data=%h expected %b/%h",
          k, ch, v, d, exp_valid[ch], exp_data[ch]); end
      idle(bad_stop ? gap + 10 : gap);
      if ($urandom_range(0, 1) == 1) consume(ch);
    end
    idle(20);
  endtask

  task automatic test_parity_and_reset;
    int pe0 = pe_cnt[1], e0;
    logic [7:0] b = 8'($urandom);
    send_frame(1, 8'h07, 1'b1, 1'b1, BIT);
    model_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
    idle(10);
    n_checks++;
    if (pe_cnt[1] - pe0 != 1 || val_b !== exp_valid[1])
      begin n_errors++; $display("FAIL parity_err_07: pe+%0d valid=%b expected 1/%b",
        pe_cnt[1] - pe0, val_b, exp_valid[1]); end
    if (exp_valid[1]) consume(1);
    send_frame(1, b, 1'b0, 1'b1, BIT);
    model_frame(1, b, 1'b0, 1'b0, 1'b0);
    idle(10);
    n_checks++;
    if (val_b !== 1'b1 || data_b !== b)
      begin n_errors++; $display("FAIL parity_good: valid=%b data=%h expected 1/%h", val_b, data_b, b); end
    // Abort a zero byte mid-frame; the line stays low through release, so no new edge.
    drive_bit(1, 1'b0, BIT);
    drive_bit(1, 1'b0, 3 * BIT);
    e0 = fe_cnt[1] + pe_cnt[1] + ov_cnt[1];
    rst = 1'b1;
    exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
    exp_data[0]  = 8'h00; exp_data[1]  = 8'h00;
    idle(3);
    n_checks++;
    if ({data_b, val_b, busy_b, fe_b, pe_b, ov_b, val_a, busy_a} !== '0)
      begin n_errors++; $display("FAIL midframe_reset: data=%h flags=%b expected zero",
        data_b, {val_b, busy_b, fe_b, pe_b, ov_b, val_a, busy_a}); end
    rst = 1'b0;
    drive_bit(1, 1'b0, 5 * BIT);
    drive_bit(1, 1'b1, 3 * BIT);
    n_checks++;
    if (val_b !== 1'b0 || busy_b !== 1'b0 || fe_cnt[1] + pe_cnt[1] + ov_cnt[1] != e0)
      begin n_errors++; $display("FAIL post_reset_quiet: valid=%b busy=%b new pulses=%0d expected 0/0/0",
        val_b, busy_b, fe_cnt[1] + pe_cnt[1] + ov_cnt[1] - e0); end
    b = 8'($urandom);
    send_frame(1, b, 1'b0, 1'b1, BIT);
    model_frame(1, b, 1'b0, 1'b0, 1'b0);
    idle(10);
    n_checks++;
    if (val_b !== 1'b1 || data_b !== b)
      begin n_errors++; $display("FAIL post_reset_rx: valid=%b data=%h expected 1/%h", val_b, data_b, b); end
    consume(1);
    idle(5);
  endtask

  task automatic test_scoreboard;
    n_checks++;
    if (got_a.size() != exp_got_a.size() || got_b.size() != exp_got_b.size())
      begin n_errors++; $display("FAIL transfer_count: got %0d/%0d expected %0d/%0d",
        got_a.size(), got_b.size(), exp_got_a.size(), exp_got_b.size()); end
    for (int i = 0; i < got_a.size() && i < exp_got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_got_a[i])
        begin n_errors++; $display("FAIL transfer_a%0d: got %h expected %h", i, got_a[i], exp_got_a[i]); end
    end
    for (int i = 0; i < got_b.size() && i < exp_got_b.size(); i++) begin
      n_checks++;
      if (got_b[i] !== exp_got_b[i])
        begin n_errors++; $display("FAIL transfer_b%0d: got %h expected %h", i, got_b[i], exp_got_b[i]); end
    end
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (fe_cnt[c] != exp_fe[c] || pe_cnt[c] != exp_pe[c] || ov_cnt[c] != exp_ov[c])
        begin n_errors++; $display("FAIL pulse_totals ch%0d: fe/pe/ov %0d/%0d/%0d expected %0d/%0d/%0d",
          c, fe_cnt[c], pe_cnt[c], ov_cnt[c], exp_fe[c], exp_pe[c], exp_ov[c]); end
    end
    n_checks++;
    if (unstable[0] + unstable[1] != 0)
      begin n_errors++; $display("FAIL data_stability: %0d changes while held, expected 0",
        unstable[0] + unstable[1]); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_false_start();
    test_random();
    test_parity_and_reset();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-parallel UART receiver for the UART interface. It recovers 8N1 (optionally parity) frames from the asynchronous `terminal_rx` pin using oversampling and majority voting. Received bytes are presented on a single-entry valid/ready output, with framing, parity and overrun reporting. It is the receive-side counterpart of the existing transmit path; the `terminal_tx` to `terminal_rx` loopback exercises both ends.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: system clock frequency.
- `BAUD`, default 115200: line rate.
- `OVERSAMPLE`, default 16: ticks per bit; even, ≥8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `clk_100mhz`, input, 1: system clock. All logic is on the rising edge.
- `sys_rst_i`, input, 1: reset, asynchronous, active-high.
- `terminal_rx`, input, 1: asynchronous serial line, idle high.
- `rx_data_o`, output, 8: received byte, LSB first on the line.
- `rx_valid_o`, output, 1: `rx_data_o` holds an unconsumed byte.
- `rx_ready_i`, input, 1: consumer accepts the byte.
- `busy_o`, output, 1: high whenever the FSM is not in IDLE.
- `frame_err_o`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err_o`, output, 1: one-cycle pulse on parity mismatch. Tied 0 when `PARITY`=0.
- `overrun_o`, output, 1: one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer:** 2-flop synchronizer on `terminal_rx`. Both flops preset to 1 on reset. All decisions use the synchronized value `rxs`.
- **Tick generator:** divisor DIV = CLK_FREQ_HZ / (BAUD·OVERSAMPLE), integer truncation, minimum 1.
  - The tick counter clears when the start edge is detected.
  - One tick every DIV clocks after that.
  - Tick index `t` counts 0..OVERSAMPLE-1 within each bit.
- **Majority vote:** `rxs` is sampled at t = M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three. The decision is made on tick M+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a high-to-low transition on `rxs` moves to START. A line held low out of reset does not start a frame.
  - START: if the voted bit is 1, this is a false start: return to IDLE with no error. If 0, go to DATA with bit index 0 at the end of the bit (t = OVERSAMPLE-1).
  - DATA: shift the voted bit into bit[index]. After index 7 completes, go to PARITY if `PARITY`≠0, else to STOP.
  - PARITY: compare the voted bit with the computed parity. Record any mismatch.
  - STOP: act on the decision at t = M+1 without waiting for the bit to end.
    - Vote 1, no parity error: deliver the byte and go to IDLE.
    - Vote 1, parity error: pulse `parity_err_o`, discard the byte, go to IDLE.
    - Vote 0: pulse `frame_err_o`, discard the byte, go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE.
- **Delivery and holding register:**
  - If `rx_valid_o`=0, or `rx_ready_i`=1 in the same cycle: load `rx_data_o` and set `rx_valid_o`=1.
  - Otherwise: keep the old byte, drop the new one, pulse `overrun_o`.
- **Handshake:** a transfer occurs in a cycle with `rx_valid_o` && `rx_ready_i`. `rx_valid_o` clears after the transfer unless a new byte is loaded in that same cycle.
- `rx_data_o` is stable while `rx_valid_o`=1 and no transfer has occurred.

## Timing
- **Reset values:** `rx_data_o`=0x00. `rx_valid_o`, `busy_o`, `frame_err_o`, `parity_err_o`, `overrun_o` = 0. FSM in IDLE. Tick and bit counters = 0.
- **Reset mid-frame:** aborts immediately, no error pulses. After release the block waits for a fresh falling edge.
- **Input latency:** 2 clocks (synchronizer) from pin to `rxs`.
- **Byte latency:** `rx_valid_o` rises 1 clock after the stop-bit decision. That is about (1+8+P)·OVERSAMPLE·DIV + (M+1)·DIV + 3 clocks after the start edge on the pin, where P=1 if parity is enabled.
- **Error pulse timing:** error and overrun pulses are exactly 1 clock wide and coincide with the cycle the byte would have loaded.
- **Back-to-back frames:** returning to IDLE mid-stop-bit lets a start bit that immediately follows the stop bit be caught.
- **Line-rate tolerance:** ±3% baud mismatch is received error-free at OVERSAMPLE=16.
- **Simultaneous events:** load and consume in the same cycle gives a new byte with `rx_valid_o` staying 1 and no overrun.

## Test plan
Unless stated, benches use BAUD=1_000_000, OVERSAMPLE=16, so DIV=6 and the bit time is 96 clocks.
1. Send 0x55 as 8N1. Expect `rx_data_o`=0x55 and `rx_valid_o`=1 until `rx_ready_i` pulses. Expect `busy_o` to drop mid-stop-bit. Expect no error pulses.
2. Send 0xA3 then 0x0F back-to-back with `rx_ready_i` held 1. Expect two valid bytes, 0xA3 then 0x0F. Expect `overrun_o` never pulses.
3. Send 0x11 then 0x22 with `rx_ready_i`=0. Expect `rx_data_o` to stay 0x11 and `overrun_o` to pulse once. Raising `rx_ready_i` then consumes 0x11 and clears `rx_valid_o`.
4. Send 0x3C with the stop bit driven low, then idle high. Expect `frame_err_o` to pulse once, `rx_valid_o` to stay 0, and the FSM to pass through BREAK to IDLE. A following 0x7E is received correctly.
5. Drive a 40-clock low glitch on an idle line. Expect a false start: no valid, no errors, `busy_o` high for fewer than 96 clocks.
6. With PARITY=2, send 0x07 with the parity bit = 0 (wrong). Expect `parity_err_o` to pulse once and no valid. Then assert `sys_rst_i` mid-frame on a later byte: all outputs return to 0 and nothing is delivered.
